// File: rtl/calc_pkg.sv
// Shared calculator datapath types: BCD digits, the signed decimal number
// format, and the operand-entry key and state encodings.
package calc_pkg;

  localparam int NumDigits = 8;
  localparam int CountW    = $clog2(NumDigits) + 1;
  localparam int ExpW      = 8;

  typedef logic [3:0]                bcd_t;
  typedef bcd_t [NumDigits-1:0]      sig_t;
  typedef logic [CountW-1:0]         count_t;

  // significand[0] is the least-significant digit
  typedef struct packed {
    logic                   error;
    logic                   sign;
    logic signed [ExpW-1:0] exponent;
    sig_t                   significand;
  } num_t;

  typedef enum logic [2:0] {
    KeyDigit     = 3'd0,
    KeyBackspace = 3'd1,
    KeyNegate    = 3'd2,
    KeyClear     = 3'd3,
    KeyEnter     = 3'd4
  } key_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    HOLD  = 2'd2
  } num_entry_state_e;

  localparam count_t MaxCount = count_t'(NumDigits);

  // Integer operand; a zero significand never carries a minus sign.
  function automatic num_t make_operand(input logic sign, input sig_t sig);
    num_t n;
    n.error       = 1'b0;
    n.sign        = sign && (sig != '0);
    n.exponent    = '0;
    n.significand = sig;
    return n;
  endfunction

endpackage

// File: rtl/num_entry_if.sv
// Keypad-in / operand-out bundle of the operand-entry stage.
// slave is the num_entry side, master is the keypad/ALU/display side.
interface num_entry_if;
  import calc_pkg::*;

  logic            key_valid_i;
  key_op_e         key_op_i;
  bcd_t            key_digit_i;
  logic            key_ready_o;
  logic            num_valid_o;
  logic            num_ready_i;
  num_t            num_o;
  num_t            live_o;
  count_t          digit_count_o;
  logic            overflow_o;

  modport slave (
    input  key_valid_i, key_op_i, key_digit_i, num_ready_i,
    output key_ready_o, num_valid_o, num_o, live_o, digit_count_o, overflow_o
  );

  modport master (
    output key_valid_i, key_op_i, key_digit_i, num_ready_i,
    input  key_ready_o, num_valid_o, num_o, live_o, digit_count_o, overflow_o
  );
endinterface

// File: rtl/num_entry.sv
// Operand entry: accumulates keypad events into a BCD integer and offers the
// finished operand to the ALU over valid/ready.
module num_entry
  import calc_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  num_entry_if.slave  bus
);

  num_entry_state_e r_state, w_state_next;
  sig_t             r_sig, w_sig_next;
  logic             r_sign, w_sign_next;
  count_t           r_count, w_count_next;
  num_t             r_num, w_num_next;
  logic             r_overflow, w_overflow_next;
  logic             w_key_fire;

  assign w_key_fire = bus.key_valid_i && (r_state != HOLD);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_sig      <= '0;
      r_sign     <= 1'b0;
      r_count    <= '0;
      r_num      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_sig      <= w_sig_next;
      r_sign     <= w_sign_next;
      r_count    <= w_count_next;
      r_num      <= w_num_next;
      r_overflow <= w_overflow_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_sig_next      = r_sig;
    w_sign_next     = r_sign;
    w_count_next    = r_count;
    w_num_next      = r_num;
    w_overflow_next = 1'b0;

    if (r_state == HOLD) begin
      // num_o keeps the last operand after the handshake; only the entry clears
      if (bus.num_ready_i) begin
        w_state_next = IDLE;
        w_sig_next   = '0;
        w_sign_next  = 1'b0;
        w_count_next = '0;
      end
    end else if (w_key_fire) begin
      case (bus.key_op_i)
        KeyDigit: begin
          if ((bus.key_digit_i <= 4'd9) &&
              !((r_count == '0) && (bus.key_digit_i == 4'd0))) begin
            if (r_count < MaxCount) begin
              w_sig_next   = {r_sig[NumDigits-2:0], bus.key_digit_i};
              w_count_next = r_count + count_t'(1);
              w_state_next = ENTRY;
            end else begin
              w_overflow_next = 1'b1;
            end
          end
        end
        KeyBackspace: begin
          w_sig_next   = {4'h0, r_sig[NumDigits-1:1]};
          w_count_next = (r_count == '0) ? '0 : r_count - count_t'(1);
          if (w_count_next == '0) begin
            w_sign_next  = 1'b0;
            w_state_next = IDLE;
          end
        end
        KeyNegate: begin
          w_sign_next  = !r_sign;
          w_state_next = ((r_count != '0) || !r_sign) ? ENTRY : IDLE;
        end
        KeyClear: begin
          w_sig_next   = '0;
          w_sign_next  = 1'b0;
          w_count_next = '0;
          w_state_next = IDLE;
        end
        KeyEnter: begin
          w_num_next   = make_operand(r_sign, r_sig);
          w_state_next = HOLD;
        end
        default: ;
      endcase
    end
  end

  assign bus.key_ready_o   = (r_state != HOLD);
  assign bus.num_valid_o   = (r_state == HOLD);
  assign bus.num_o         = r_num;
  assign bus.digit_count_o = r_count;
  assign bus.overflow_o    = r_overflow;
  assign bus.live_o        = '{error: 1'b0, sign: r_sign, exponent: '0, significand: r_sig};

endmodule

// File: tb/tb_num_entry.sv
// Directed bench for num_entry: key sequences with hand-computed operands,
// overflow, backspace saturation, HOLD back-pressure and reset during HOLD.
module tb_num_entry;
  import calc_pkg::*;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  num_entry_if bus ();

  num_entry dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, got);
    end
  endtask

  function automatic longint to_int(input num_t n);
    longint v = 0;
    for (int i = NumDigits - 1; i >= 0; i--) v = v * 10 + longint'(n.significand[i]);
    return n.sign ? -v : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input key_op_e op, input bcd_t d);
    bus.key_valid_i = 1'b1;
    bus.key_op_i    = op;
    bus.key_digit_i = d;
    tick();
    bus.key_valid_i = 1'b0;
  endtask

  task automatic handshake();
    bus.num_ready_i = 1'b1;
    tick();
    bus.num_ready_i = 1'b0;
  endtask

  initial begin
    tests_run       = 0;
    tests_failed    = 0;
    rst             = 1'b1;
    bus.key_valid_i = 1'b0;
    bus.key_op_i    = KeyDigit;
    bus.key_digit_i = 4'd0;
    bus.num_ready_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_key_ready", 64'(bus.key_ready_o), 64'd1);
    check("rst_valid",     64'(bus.num_valid_o), 64'd0);
    check("rst_num",       64'(bus.num_o), 64'd0);
    check("rst_live",      64'(bus.live_o), 64'd0);
    check("rst_count",     64'(bus.digit_count_o), 64'd0);
    check("rst_ovf",       64'(bus.overflow_o), 64'd0);

    // 1,2,3 Enter with ready already high
    press(KeyDigit, 4'd1);
    press(KeyDigit, 4'd2);
    press(KeyDigit, 4'd3);
    check("123_live", 64'(bus.live_o.significand), 64'h123);
    check("123_count", 64'(bus.digit_count_o), 64'd3);
    bus.num_ready_i = 1'b1;
    press(KeyEnter, 4'd0);
    check("123_valid", 64'(bus.num_valid_o), 64'd1);
    check("123_sig", 64'(bus.num_o.significand), 64'h0000_0123);
    check("123_sign_exp_err", {bus.num_o.sign, bus.num_o.exponent, bus.num_o.error}, 64'd0);
    check("123_value", 64'(to_int(bus.num_o)), 64'd123);
    check("123_kready_hold", 64'(bus.key_ready_o), 64'd0);
    tick();
    bus.num_ready_i = 1'b0;
    check("123_valid_1cyc", 64'(bus.num_valid_o), 64'd0);
    check("123_idle_count", 64'(bus.digit_count_o), 64'd0);
    check("123_idle_live", 64'(bus.live_o), 64'd0);
    check("123_kready_back", 64'(bus.key_ready_o), 64'd1);

    // leading zeros, negate
    press(KeyDigit, 4'd0);
    press(KeyDigit, 4'd0);
    check("lead0_count", 64'(bus.digit_count_o), 64'd0);
    press(KeyDigit, 4'd5);
    press(KeyNegate, 4'd0);
    check("m5_count", 64'(bus.digit_count_o), 64'd1);
    check("m5_live_sign", 64'(bus.live_o.sign), 64'd1);
    press(KeyEnter, 4'd0);
    check("m5_value", 64'(to_int(bus.num_o)), 64'(-64'sd5));
    handshake();

    // negative zero is offered as +0
    press(KeyDigit, 4'd0);
    press(KeyNegate, 4'd0);
    check("nz_live_sign", 64'(bus.live_o.sign), 64'd1);
    check("nz_count", 64'(bus.digit_count_o), 64'd0);
    press(KeyEnter, 4'd0);
    check("nz_num", 64'(bus.num_o), 64'd0);
    handshake();

    // illegal digit ignored, ninth digit overflows
    press(KeyDigit, 4'd12);
    check("bad_digit_count", 64'(bus.digit_count_o), 64'd0);
    for (int i = 9; i >= 2; i--) press(KeyDigit, bcd_t'(i));
    check("full_ovf_low", 64'(bus.overflow_o), 64'd0);
    press(KeyDigit, 4'd1);
    check("ovf_pulse", 64'(bus.overflow_o), 64'd1);
    check("ovf_live", 64'(bus.live_o.significand), 64'h9876_5432);
    check("ovf_count", 64'(bus.digit_count_o), 64'd8);
    tick();
    check("ovf_one_cycle", 64'(bus.overflow_o), 64'd0);
    press(KeyClear, 4'd0);
    check("clear_live", 64'(bus.live_o), 64'd0);

    // backspace down to zero and saturation
    press(KeyDigit, 4'd4);
    press(KeyDigit, 4'd5);
    press(KeyDigit, 4'd6);
    press(KeyBackspace, 4'd0);
    press(KeyBackspace, 4'd0);
    check("bs_live", 64'(bus.live_o.significand), 64'h4);
    check("bs_count", 64'(bus.digit_count_o), 64'd1);
    press(KeyBackspace, 4'd0);
    check("bs_zero_live", 64'(bus.live_o), 64'd0);
    check("bs_zero_count", 64'(bus.digit_count_o), 64'd0);
    press(KeyBackspace, 4'd0);
    check("bs_sat_count", 64'(bus.digit_count_o), 64'd0);

    // back-pressure: keys pending during HOLD are ignored
    press(KeyDigit, 4'd4);
    press(KeyDigit, 4'd2);
    press(KeyEnter, 4'd0);
    bus.key_valid_i = 1'b1;
    bus.key_op_i    = KeyClear;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) bus.key_op_i = KeyDigit;
      bus.key_digit_i = 4'd7;
      tick();
      check("bp_kready", 64'(bus.key_ready_o), 64'd0);
      check("bp_num", 64'(to_int(bus.num_o)), 64'd42);
      check("bp_live", 64'(bus.live_o.significand), 64'h42);
    end
    bus.num_ready_i = 1'b1;
    tick();
    bus.num_ready_i = 1'b0;
    check("bp_after_hs_valid", 64'(bus.num_valid_o), 64'd0);
    check("bp_after_hs_live", 64'(bus.live_o), 64'd0);
    check("bp_after_hs_kready", 64'(bus.key_ready_o), 64'd1);
    tick();
    bus.key_valid_i = 1'b0;
    check("bp_pending7_live", 64'(bus.live_o.significand), 64'h7);
    check("bp_pending7_count", 64'(bus.digit_count_o), 64'd1);

    // reset during HOLD with ready and a key present
    press(KeyEnter, 4'd0);
    check("rh_valid_before", 64'(bus.num_valid_o), 64'd1);
    rst             = 1'b1;
    bus.num_ready_i = 1'b1;
    bus.key_valid_i = 1'b1;
    bus.key_op_i    = KeyDigit;
    bus.key_digit_i = 4'd3;
    tick();
    rst             = 1'b0;
    bus.num_ready_i = 1'b0;
    bus.key_valid_i = 1'b0;
    check("rh_valid", 64'(bus.num_valid_o), 64'd0);
    check("rh_num", 64'(bus.num_o), 64'd0);
    check("rh_live", 64'(bus.live_o), 64'd0);
    check("rh_count", 64'(bus.digit_count_o), 64'd0);
    check("rh_kready", 64'(bus.key_ready_o), 64'd1);
    check("rh_ovf", 64'(bus.overflow_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
